// File: rtl/mem_wb_pipe.sv
// ----------------------------------------------------------------------------
// mem_wb_pipe
//
// MEM -> WB pipeline stage. Carries the regfile write triple (destination
// address, write enable, data) and, when built with MEM_WB_HILO_EN defined,
// the HI/LO write (enable, HI, LO). A valid/ready handshake with a 2-entry
// skid buffer (MAIN + SKID) absorbs writeback-side stalls without dropping or
// duplicating entries. A synchronous flush discards everything buffered.
//
// Build option:
//   MEM_WB_HILO_EN  - adds the HI/LO payload ports and their storage.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   flush          synchronous flush; wins over accept and pop
//   in_valid       memory stage presents an entry
//   in_ready       stage can accept (registered: skid buffer empty)
//   in_dest_addr   destination register
//   in_wreg        regfile write request
//   in_wdata       regfile write data
//   in_hilo_we     HI/LO write request          (MEM_WB_HILO_EN)
//   in_hi, in_lo   HI/LO data                   (MEM_WB_HILO_EN)
//   out_valid      head entry valid
//   out_ready      writeback consumes head this cycle
//   out_dest_addr  head destination register
//   out_wreg       head regfile write enable, qualified by out_valid
//   out_wdata      head write data
//   out_hilo_we    head HI/LO write enable, qualified (MEM_WB_HILO_EN)
//   out_hi, out_lo head HI/LO data              (MEM_WB_HILO_EN)
//   occupancy      entries held: 0, 1 or 2
// ----------------------------------------------------------------------------
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_dest_addr,
   input  logic              in_wreg,
   input  logic [DATA_W-1:0] in_wdata,
`ifdef MEM_WB_HILO_EN
   input  logic              in_hilo_we,
   input  logic [DATA_W-1:0] in_hi,
   input  logic [DATA_W-1:0] in_lo,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_dest_addr,
   output logic              out_wreg,
   output logic [DATA_W-1:0] out_wdata,
`ifdef MEM_WB_HILO_EN
   output logic              out_hilo_we,
   output logic [DATA_W-1:0] out_hi,
   output logic [DATA_W-1:0] out_lo,
`endif
   output logic [1:0]        occupancy
);

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
`ifdef MEM_WB_HILO_EN
      logic              hilo_we;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
`endif
      logic [REG_AW-1:0] dest_addr;
      logic              wreg;
      logic [DATA_W-1:0] wdata;
   } entry_t;

   state_t state, state_nxt;
   entry_t main_q, skid_q, in_entry;
   logic   accept, pop;
   logic   load_main_in, load_main_skid, load_skid;

   always_comb begin
      in_entry           = '0;
      in_entry.dest_addr = in_dest_addr;
      in_entry.wreg      = in_wreg;
      in_entry.wdata     = in_wdata;
`ifdef MEM_WB_HILO_EN
      in_entry.hilo_we   = in_hilo_we;
      in_entry.hi        = in_hi;
      in_entry.lo        = in_lo;
`endif
   end

   // in_ready comes straight from the state register, so the memory stage
   // never sees a combinational path from out_ready.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Next-state and payload-move decode.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         // Flush beats accept and pop; payload registers are left untouched.
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_main_in = 1'b1;
                  state_nxt    = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = FULL;
               end else if (pop) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  load_main_skid = 1'b1;
                  state_nxt      = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Payload storage.
   // NOTE: these are only two registers, and the reset value is visible on
   // the outputs, so they are reset along with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= in_entry;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_entry;
      end
   end

   assign out_dest_addr = main_q.dest_addr;
   assign out_wreg      = main_q.wreg & out_valid;
   assign out_wdata     = main_q.wdata;
`ifdef MEM_WB_HILO_EN
   assign out_hilo_we   = main_q.hilo_we & out_valid;
   assign out_hi        = main_q.hi;
   assign out_lo        = main_q.lo;
`endif
   assign occupancy     = state;

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline stage; successor to the fixed-width memory/writeback register.
- Carries the regfile write triple (dest addr, write enable, data) and, optionally, the HI/LO write.
- Adds a valid/ready handshake with a 2-entry skid buffer, so writeback-side stalls never drop or duplicate an instruction, plus a synchronous flush that inserts a bubble.
- Sits between the memory stage and the regfile/HILO write ports; its outputs also feed forwarding logic.

Parameters:
- DATA_W, 32, width of regfile write data and of HI/LO.
- REG_AW, 5, regfile address width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  memory stage presents an entry
- in_ready  output  1  stage can accept; registered (= skid buffer empty)
- in_dest_addr  input  REG_AW  destination register
- in_wreg  input  1  regfile write request
- in_wdata  input  DATA_W  regfile write data
- in_hilo_we  input  1  HI/LO write request (MEM_WB_HILO_EN only)
- in_hi  input  DATA_W  HI data (MEM_WB_HILO_EN only)
- in_lo  input  DATA_W  LO data (MEM_WB_HILO_EN only)
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback consumes head this cycle
- out_dest_addr  output  REG_AW  head dest addr
- out_wreg  output  1  head regfile write enable, qualified by out_valid
- out_wdata  output  DATA_W  head write data
- out_hilo_we  output  1  head HI/LO write enable, qualified by out_valid (MEM_WB_HILO_EN only)
- out_hi  output  DATA_W  head HI (MEM_WB_HILO_EN only)
- out_lo  output  DATA_W  head LO (MEM_WB_HILO_EN only)
- occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (async, rst=1): main and skid valid cleared; all payload registers cleared to 0; out_valid=0, out_wreg=0, out_hilo_we=0, occupancy=0, in_ready=1. Takes effect immediately, regardless of clk, including mid-transfer.
- Handshake events:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Payload is sampled only on accept.
- State is held in two registers, MAIN (head, drives outputs) and SKID.
  - EMPTY (occ 0): accept → MAIN loaded, out_valid=1 next cycle (latency 1).
  - ONE (occ 1):
    - accept & pop → MAIN reloaded with new entry, stays ONE.
    - accept & !pop → entry goes to SKID, becomes FULL; in_ready=0 next cycle.
    - pop & !accept → EMPTY.
  - FULL (occ 2): in_ready=0, so no accept is possible.
    - pop → SKID moves to MAIN, becomes ONE; in_ready=1 next cycle.
- Order is strictly FIFO; no entry is ever dropped or duplicated except by flush.
- While out_ready=0, all out_* hold their values.
- Flush has priority over accept and pop in the same cycle.
  - Next cycle: occupancy=0, out_valid=0, in_ready=1.
  - An entry accepted in the flush cycle is discarded.
  - Payload registers keep their last values (not observable through the qualified enables).
- out_wreg and out_hilo_we are ANDed with out_valid; raw payload may be stale when out_valid=0.
- A bubble (in_valid=1, in_wreg=0) is a normal entry and occupies a slot.
- Widths pass through unmodified; no sign extension or alignment.

Optional Feature:
- MEM_WB_HILO_EN defined:
  - in_hilo_we/in_hi/in_lo and out_hilo_we/out_hi/out_lo exist.
  - They are buffered in MAIN and SKID exactly like the regfile payload.
  - Reset value 0.
- Not defined:
  - Those six ports and their storage are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then single entry: rst pulse; in_valid=1, dest=5'd3, wreg=1, wdata=32'hDEADBEEF, out_ready=1 → next cycle out_valid=1, out_dest_addr=3, out_wdata=DEADBEEF, out_wreg=1; following cycle (no input) out_valid=0, out_wreg=0.
- Back-pressure fill: out_ready=0, push A=32'h1 then B=32'h2 → occupancy 1 then 2, in_ready=0 after B, head holds A; raise out_ready → A out, then B out; in_ready=1 the cycle after A pops; no C lost when presented during FULL.
- Streaming: out_ready=1, 8 consecutive entries 32'h10..32'h17 → each appears exactly one cycle after accept, in order, occupancy never exceeds 1.
- Flush priority: FULL state with A, B, plus flush=1 and out_ready=1 in the same cycle → next cycle occupancy=0, out_valid=0, out_wreg=0, in_ready=1; neither A (beyond that cycle) nor B appears later.
- Async reset mid-operation: FULL state, assert rst between clock edges → outputs zero immediately, occupancy=0, in_ready=1 without a clock edge.
- MEM_WB_HILO_EN: push hilo_we=1, hi=32'hAAAA0000, lo=32'h0000BBBB with out_ready=0, then release → out_hilo_we=1 with matching HI/LO on the head cycle only; out_hilo_we=0 whenever out_valid=0.
